layer_test_seq: RTL and testbench

Sequencer for the per-layer serial link self-test in the 3D stack. It runs on the divided link clock alongside the deserializer, self-test and serializer datapath. It decides when the serializer forwards received data and when it injects a test burst. In non-first layers it finds sync in the deserialized word stream and checks a PRBS burst word by word. It reports pass, fail or timeout, plus an error count.

---
 rtl/layer_test_pkg.sv | 22 ++
 rtl/prbs_word_gen.sv | 38 +++
 rtl/layer_test_seq.sv | 181 ++++++++++++++++++
 tb/tb_layer_test_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/layer_test_pkg.sv
// Shared types and constants for the per-layer serial link self-test sequencer.
// Holds the sequencer state encoding, the default burst header and PRBS seed,
// and the 32-bit LFSR successor function used by both burst generation and checking.
package layer_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_HUNT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [31:0] DEF_SYNC_WORD = 32'hA5A5_5A5A;
  localparam logic [31:0] DEF_SEED      = 32'h0000_0001;

  // One PRBS step per word: shift left, feed back taps 31, 21, 1 and 0.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

endpackage

// File: rtl/prbs_word_gen.sv
// PRBS word source shared by burst transmission and burst checking.
// Ports: clk/rst (async active-high); load_i reloads SEED (wins over step_i);
// step_i advances the LFSR by one word; word_o is the current PRBS word.
module prbs_word_gen
  import layer_test_pkg::*;
#(
  parameter logic [31:0] SEED = DEF_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        step_i,
  output logic [31:0] word_o
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED;
    end else if (step_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign word_o = lfsr_q;

endmodule

// File: rtl/layer_test_seq.sv
// Per-layer link self-test sequencer: injects a SYNC + PRBS burst (source layer)
// or hunts for SYNC in the deserialized stream and checks the burst word by word.
// Ports: clk/rst; f_layer, start, de_word in; ser_en, tx_sel, tx_word, tx_load,
// busy, done, pass, timeout, err_cnt out. All outputs decode registered state.
module layer_test_seq
  import layer_test_pkg::*;
#(
  parameter int                  WORD_W    = 32,
  parameter int                  N_WORDS   = 16,
  parameter logic [WORD_W-1:0]   SYNC_WORD = WORD_W'(DEF_SYNC_WORD),
  parameter logic [31:0]         SEED      = DEF_SEED,
  parameter int                  ERR_W     = 8,
  parameter int                  TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_layer,
  input  logic              start,
  input  logic [WORD_W-1:0] de_word,
  output logic              ser_en,
  output logic              tx_sel,
  output logic [WORD_W-1:0] tx_word,
  output logic              tx_load,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int BIT_W  = $clog2(WORD_W);
  localparam int WCNT_W = $clog2(N_WORDS + 2);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
  localparam logic [BIT_W-1:0]  BIT_PENUL = BIT_W'(WORD_W - 2);
  localparam logic [WCNT_W-1:0] WCNT_N    = WCNT_W'(N_WORDS);
  localparam logic [WCNT_W-1:0] WCNT_TAIL = WCNT_W'(N_WORDS + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

  state_t              state_q,    state_d;
  logic [BIT_W-1:0]    bit_cnt_q,  bit_cnt_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt_q,  tmo_cnt_d;
  logic [ERR_W-1:0]    err_cnt_q,  err_cnt_d;
  logic                pass_q,     pass_d;
  logic                timeout_q,  timeout_d;

  logic                accept;
  logic                bit_last;
  logic                prbs_step;
  logic [31:0]         prbs_word;
  logic [WORD_W-1:0]   exp_word;

  assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign bit_last = (bit_cnt_q == BIT_LAST);
  assign exp_word = WORD_W'(prbs_word);

  // In SEND, slot 0 carries SYNC and slots 1..N carry PRBS words, so the LFSR
  // advances at the end of each data slot. In CHECK it advances on every compare.
  always_comb begin
    prbs_step = 1'b0;
    if (state_q == ST_SEND) begin
      prbs_step = bit_last && (word_cnt_q != '0) && (word_cnt_q <= WCNT_N);
    end else if (state_q == ST_CHECK) begin
      prbs_step = bit_last && (word_cnt_q < WCNT_N);
    end
  end

  prbs_word_gen #(
    .SEED (SEED)
  ) u_prbs (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept),
    .step_i (prbs_step),
    .word_o (prbs_word)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    err_cnt_d  = err_cnt_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = f_layer ? ST_SEND : ST_HUNT;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          tmo_cnt_d  = '0;
          err_cnt_d  = '0;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
        end
      end

      ST_SEND: begin
        bit_cnt_d = bit_last ? '0 : bit_cnt_q + 1'b1;
        if (bit_last) begin
          word_cnt_d = word_cnt_q + 1'b1;
        end
        // The slot after the last load is cut one cycle short so that done
        // becomes visible exactly (N_WORDS+2)*WORD_W cycles after start.
        if ((word_cnt_q == WCNT_TAIL) && (bit_cnt_q == BIT_PENUL)) begin
          state_d = ST_DONE;
          pass_d  = 1'b1;
        end
      end

      ST_HUNT: begin
        if (de_word == SYNC_WORD) begin
          state_d   = ST_CHECK;
          bit_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      ST_CHECK: begin
        // One idle cycle after the last compare lets its error count in pass.
        if (word_cnt_q == WCNT_N) begin
          state_d = ST_DONE;
          pass_d  = (err_cnt_q == '0);
        end else begin
          bit_cnt_d = bit_last ? '0 : bit_cnt_q + 1'b1;
          if (bit_last) begin
            word_cnt_d = word_cnt_q + 1'b1;
            if ((de_word != exp_word) && !(&err_cnt_q)) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      err_cnt_q  <= '0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      err_cnt_q  <= err_cnt_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
    end
  end

  assign busy    = (state_q == ST_SEND) || (state_q == ST_HUNT) || (state_q == ST_CHECK);
  assign ser_en  = busy;
  assign tx_sel  = (state_q == ST_SEND);
  assign tx_load = (state_q == ST_SEND) && (bit_cnt_q == '0) && (word_cnt_q <= WCNT_N);
  assign tx_word = (state_q != ST_SEND) ? '0 :
                   (word_cnt_q == '0)   ? SYNC_WORD : exp_word;
  assign done    = (state_q == ST_DONE);
  assign pass    = pass_q;
  assign timeout = timeout_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_layer_test_seq.sv
// Randomized scoreboard bench for layer_test_seq: a default instance and a
// 2-bit error counter instance share all stimulus; expected tx words and
// run results are queued at start and checked by a negedge monitor.
module tb_layer_test_seq;

  localparam int          W    = 32;
  localparam int          N    = 16;
  localparam int          TMO  = 1023;
  localparam logic [31:0] SYNC = 32'hA5A5_5A5A;
  localparam logic [31:0] SEED = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_layer;
  logic        start;
  logic [31:0] de_word;

  logic        ser_en, tx_sel, tx_load, busy, done, pass, timeout;
  logic [31:0] tx_word;
  logic [7:0]  err_cnt;
  logic        ser_en_b, tx_sel_b, tx_load_b, busy_b, done_b, pass_b, timeout_b;
  logic [31:0] tx_word_b;
  logic [1:0]  err_cnt_b;

  always #5 clk = ~clk;

  layer_test_seq u_dut (
    .clk(clk), .rst(rst), .f_layer(f_layer), .start(start), .de_word(de_word),
    .ser_en(ser_en), .tx_sel(tx_sel), .tx_word(tx_word), .tx_load(tx_load),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_cnt(err_cnt)
  );

  layer_test_seq #(.ERR_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .f_layer(f_layer), .start(start), .de_word(de_word),
    .ser_en(ser_en_b), .tx_sel(tx_sel_b), .tx_word(tx_word_b), .tx_load(tx_load_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .timeout(timeout_b), .err_cnt(err_cnt_b)
  );

  typedef struct { int cyc; logic [31:0] word; } tx_t;
  typedef struct { int cyc; bit pass; bit tmo; int err_a; int err_b; } res_t;

  tx_t         tx_q[$];
  res_t        res_q[$];
  logic [31:0] win[$];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [31:0] nxt(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  // Word visible on de_word during cycle j after the start cycle (j >= 1).
  function automatic logic [31:0] getw(input int j);
    if (j >= 1 && j <= win.size()) return win[j-1];
    return '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  logic done_prev = 1'b0;
  tx_t  te;
  res_t re;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_outs_a", {ser_en, tx_sel, tx_load, busy, done, pass, timeout, err_cnt, tx_word}, '0);
      chk("rst_outs_b", {ser_en_b, tx_sel_b, tx_load_b, busy_b, done_b, pass_b, timeout_b, err_cnt_b, tx_word_b}, '0);
      done_prev = 1'b0;
    end else begin
      chk("ser_en_vs_busy", ser_en, busy);
      if (tx_load) begin
        chk("tx_load_expected", tx_q.size() > 0, 1);
        if (tx_q.size() > 0) begin
          te = tx_q.pop_front();
          chk("tx_load_cycle", cyc, te.cyc);
          chk("tx_word", tx_word, te.word);
          chk("tx_sel_on_load", tx_sel, 1);
        end
      end
      if (done && !done_prev) begin
        chk("done_expected", res_q.size() > 0, 1);
        if (res_q.size() > 0) begin
          re = res_q.pop_front();
          chk("done_cycle", cyc, re.cyc);
          chk("pass", pass, re.pass);
          chk("timeout", timeout, re.tmo);
          chk("err_cnt", err_cnt, re.err_a);
          chk("done_b", done_b, 1);
          chk("pass_b", pass_b, re.pass);
          chk("err_cnt_sat", err_cnt_b, re.err_b);
        end
      end
      done_prev = done;
    end
  end

  // ---------------- stimulus ----------------
  // Bit stream: glen preamble bits, optional SYNC + N PRBS words (bad[n] flips
  // one random bit of word n), then filler; de_word is its 32-bit shift window.
  task automatic build(input bit with_sync, input int glen, input logic [N-1:0] bad);
    bit          bq[$];
    logic [31:0] w, d, sh;
    int          p;
    win.delete();
    for (int i = 0; i < glen; i++) bq.push_back(with_sync ? 1'($urandom_range(0, 1)) : 1'b0);
    if (with_sync) begin
      d = SYNC;
      for (int b = 31; b >= 0; b--) bq.push_back(d[b]);
      w = SEED;
      for (int n = 0; n < N; n++) begin
        d = w;
        if (bad[n]) begin
          p = int'($urandom_range(0, 31));
          d[p] = ~d[p];
        end
        for (int b = 31; b >= 0; b--) bq.push_back(d[b]);
        w = nxt(w);
      end
    end
    while (bq.size() < 1300) bq.push_back(with_sync ? 1'($urandom_range(0, 1)) : 1'b0);
    sh = '0;
    foreach (bq[i]) begin
      sh = {sh[30:0], bq[i]};
      win.push_back(sh);
    end
  endtask

  task automatic run(input bit f, input bit abort, input bit pulses);
    int          e0, k, m, jend;
    logic [31:0] w;
    res_t        r;
    f_layer = f;
    start   = 1'b1;
    tick();
    start = 1'b0;
    e0    = cyc;
    if (f) begin
      tx_q.push_back('{cyc: e0, word: SYNC});
      w = SEED;
      for (int i = 1; i <= N; i++) begin
        tx_q.push_back('{cyc: e0 + i * W, word: w});
        w = nxt(w);
      end
      r = '{cyc: e0 - 1 + (N + 2) * W, pass: 1'b1, tmo: 1'b0, err_a: 0, err_b: 0};
    end else begin
      k = 0;
      for (int j = 1; j <= TMO; j++) if (k == 0 && getw(j) == SYNC) k = j;
      if (k == 0) begin
        r = '{cyc: e0 + TMO, pass: 1'b0, tmo: 1'b1, err_a: 0, err_b: 0};
      end else begin
        m = 0;
        w = SEED;
        for (int n = 0; n < N; n++) begin
          if (getw(k + (n + 1) * W) != w) m++;
          w = nxt(w);
        end
        r = '{cyc: e0 + k + N * W + 1, pass: (m == 0), tmo: 1'b0,
              err_a: (m > 255) ? 255 : m, err_b: (m > 3) ? 3 : m};
      end
    end
    if (!abort) res_q.push_back(r);

    jend = abort ? 400 : 1400;
    for (int j = 1; j <= jend; j++) begin
      if (done) begin
        start = 1'b0;
        break;
      end
      start   = pulses && (j == 7 || j == 300);
      f_layer = (j == 7 || j == 300) ? ~f : f;
      de_word = getw(j);
      if (j == 100) begin
        chk("busy_mid", busy, 1);
        chk("tx_sel_mid", tx_sel, f);
      end
      tick();
    end
    start   = 1'b0;
    f_layer = f;
    if (abort) begin
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("idle_after_rst", {ser_en, tx_sel, tx_load, busy, done, pass, timeout, err_cnt, tx_word}, '0);
    end else begin
      chk("run_done", done, 1);
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    f_layer = 1'b0;
    de_word = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("idle_after_reset", {ser_en, tx_sel, tx_load, busy, done, pass, timeout, err_cnt, tx_word}, '0);

    build(1'b1, 50, '0);                                  run(1'b1, 1'b0, 1'b1);
    build(1'b1, int'($urandom_range(0, 200)), '0);        run(1'b0, 1'b0, 1'b0);
    build(1'b1, int'($urandom_range(0, 200)), 16'h0088);  run(1'b0, 1'b0, 1'b0);
    build(1'b1, int'($urandom_range(0, 200)), 16'hFFFF);  run(1'b0, 1'b0, 1'b0);
    build(1'b0, 0, '0);                                   run(1'b0, 1'b0, 1'b0);
    build(1'b1, int'($urandom_range(0, 200)), '0);        run(1'b0, 1'b1, 1'b0);
    build(1'b1, int'($urandom_range(0, 200)), '0);        run(1'b0, 1'b0, 1'b1);
    for (int t = 0; t < 4; t++) begin
      build(1'b1, int'($urandom_range(0, 300)), N'($urandom_range(0, 65535)));
      run(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
    end

    repeat (3) tick();
    chk("tx_queue_drained", tx_q.size(), 0);
    chk("result_queue_drained", res_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
